// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INS_STRIDE       = 32'd4;
    localparam int          ENTRY_W          = 64;

    // Instruction fetches are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Instruction buffer between fetch and decode: circular FIFO with
// synchronous flush, simultaneous push/pop, and registered head output.
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic                           head_valid,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != FULL) || do_pop);
    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC register, single-outstanding memory request FSM,
// and the instruction buffer toward decode.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | buffer has no guaranteed slot; waiting for decode to drain
//  REQ     | imem_req asserted with imem_addr = pc
//  WAIT    | request accepted; next response is pushed to the buffer
//  DROP    | request accepted before a redirect; next response discarded
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] npc,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_ins,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e         state;
    fetch_state_e         state_nx;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W:0]       in_flight;
    logic [ENTRY_W-1:0]   head;
    logic                 outstanding;
    logic                 room;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 space_after_push;

    assign outstanding      = (state == ST_WAIT) || (state == ST_DROP);
    assign in_flight        = {1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding};
    assign room             = in_flight < {1'b0, DEPTH_C};
    assign accept           = (state == ST_REQ) && imem_ready;
    assign pop              = if_valid && id_ready;
    assign push             = (state == ST_WAIT) && imem_rvalid && !redirect;
    // A same-cycle pop frees the slot the push takes.
    assign space_after_push = pop || (fifo_count < (DEPTH_C - CNT_W'(1)));

    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;
    assign if_ins    = head[63:32];
    assign if_pc     = head[31:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state selection; a response that coincides with a redirect is
    // already the one to discard, so no DROP visit is needed for it.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (redirect || room) state_nx = ST_REQ;
            ST_REQ:  if (imem_ready) state_nx = redirect ? ST_DROP : ST_WAIT;
            ST_WAIT: begin
                if (imem_rvalid)   state_nx = (redirect || space_after_push) ? ST_REQ : ST_IDLE;
                else if (redirect) state_nx = ST_DROP;
            end
            ST_DROP: if (imem_rvalid) state_nx = ST_REQ;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Fetch PC: redirect wins over the sequential advance on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pc <= RESET_PC;
        else if (redirect) pc <= word_align(npc);
        else if (accept)   pc <= pc + INS_STRIDE;
    end

    // pc only moves past the outstanding request by one stride (any redirect
    // suppresses the push), so the request address is recovered as pc - 4.
    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_data  ({imem_rdata, pc - INS_STRIDE}),
        .pop        (pop),
        .head_data  (head),
        .head_valid (if_valid),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_ifu_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] npc = '0;
    logic        redirect = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .npc         (npc),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ins      (if_ins),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: instruction stream as decode must see it
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_pc = RST_PC;
    bit          m_out = 0;
    bit          m_drop = 0;
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];

    // memory responder state (shared with the driver)
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data = '0;
    int unsigned mem_seq = 0;

    // stimulus knobs
    bit          k_ready = 1, k_idr = 1, k_rd = 0, k_spur = 0;
    logic [31:0] k_npc = '0;
    int          k_lat = 1;

    bit          prev_stall = 0;
    logic [31:0] prev_addr = '0;
    int          idle_cnt = 0;

    task automatic chk_log(input string name, input bit is_pop, input int idx, input logic [31:0] exp);
        int sz;
        sz = is_pop ? pop_log.size() : acc_log.size();
        if (idx >= sz) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: entry %0d missing (log holds %0d), expected 0x%08h", name, idx, sz, exp);
        end else begin
            chk(name, is_pop ? pop_log[idx] : acc_log[idx], exp);
        end
    endtask

    // Compare process: sample mid-cycle, check, then advance the model to
    // the state that must hold after the coming rising edge.
    always @(negedge clk) begin : compare
        bit     acc, rv, pp, rd;
        entry_t e;
        if (!rst_n) begin
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_if_valid", 32'(if_valid), 32'd0);
            chk("rst_if_ins", if_ins, 32'd0);
            chk("rst_if_pc", if_pc, 32'd0);
            chk("rst_pc", pc, RST_PC);
            q.delete();
            m_pc = RST_PC; m_out = 0; m_drop = 0;
            mem_busy = 0; prev_stall = 0; idle_cnt = 0;
        end else begin
            acc = imem_req && imem_ready;
            rv  = imem_rvalid && mem_busy;
            pp  = if_valid && id_ready;
            rd  = redirect;

            chk("pc", pc, m_pc);
            chk("if_valid", 32'(if_valid), 32'(q.size() != 0));
            if (if_valid && q.size() != 0) begin
                chk("if_ins", if_ins, q[0].ins);
                chk("if_pc", if_pc, q[0].pc);
            end
            if (imem_req) chk("imem_addr", imem_addr, m_pc);
            if (prev_stall) begin
                chk("stall_req_held", 32'(imem_req), 32'd1);
                chk("stall_addr_held", imem_addr, prev_addr);
            end
            if (acc) chk("slot_guaranteed", 32'(q.size() < DEPTH), 32'd1);

            if (acc || m_out || q.size() >= DEPTH) idle_cnt = 0;
            else if (imem_ready) idle_cnt++;
            chk("fetch_progress", 32'(idle_cnt > 2), 32'd0);

            prev_stall = imem_req && !imem_ready && !rd;
            prev_addr  = imem_addr;

            if (pp && !rd && q.size() != 0) begin
                pop_log.push_back(q[0].pc);
                void'(q.pop_front());
            end
            if (rv) begin
                if (!m_drop && !rd) begin
                    e.ins = mem_data;
                    e.pc  = mem_addr;
                    q.push_back(e);
                end
                m_out = 0; m_drop = 0; mem_busy = 0;
            end
            if (acc) begin
                m_out = 1; m_drop = 0;
                m_pc = m_pc + 32'd4;
                acc_log.push_back(imem_addr);
                mem_busy = 1; mem_cnt = 1; mem_lat = k_lat;
                mem_addr = imem_addr;
                mem_seq++;
                mem_data = (mem_seq * 32'h9E37_79B1) ^ imem_addr;
            end
            if (rd) begin
                q.delete();
                m_pc = npc & 32'hFFFF_FFFC;
                if (m_out) m_drop = 1;
            end
        end
    end

    // One clock of stimulus: inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        imem_ready = k_ready;
        id_ready   = k_idr;
        redirect   = k_rd;
        npc        = k_npc;
        if (mem_busy && mem_cnt >= mem_lat) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data;
        end else begin
            imem_rvalid = !mem_busy && k_spur;
            imem_rdata  = $urandom();
            if (mem_busy) mem_cnt++;
        end
    endtask

    initial begin : timeout
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin : stim
        int base, pbase, abase, rbase;
        repeat (3) tick();
        rst_n = 1'b1;

        // sequential fetch after reset release
        for (int i = 0; i < 40 && pop_log.size() < 3; i++) tick();
        chk_log("seq_acc0", 0, 0, 32'h0000_3000);
        chk_log("seq_acc1", 0, 1, 32'h0000_3004);
        chk_log("seq_acc2", 0, 2, 32'h0000_3008);
        chk_log("seq_pop0", 1, 0, 32'h0000_3000);
        chk_log("seq_pop1", 1, 1, 32'h0000_3004);
        chk_log("seq_pop2", 1, 2, 32'h0000_3008);

        // decode stall: buffer fills, fetch stops
        k_idr = 0;
        repeat (6) tick();
        chk("stall_imem_req", 32'(imem_req), 32'd0);
        chk("stall_if_valid", 32'(if_valid), 32'd1);
        base = pop_log.size();
        k_ready = 0; k_idr = 1;
        repeat (4) tick();
        chk("stall_drained", 32'(pop_log.size() - base), 32'd2);
        if (base >= 1 && pop_log.size() > base) begin
            chk_log("stall_no_loss", 1, base, pop_log[base-1] + 32'd4);
            chk_log("stall_no_dup", 1, base + 1, pop_log[base] + 32'd4);
        end
        k_ready = 1;

        // redirect during WAIT for 0x3008
        rst_n = 1'b0;
        tick(); tick();
        acc_log.delete(); pop_log.delete();
        k_lat = 3;
        rst_n = 1'b1;
        for (int i = 0; i < 60 && acc_log.size() < 3; i++) tick();
        chk_log("wait_rd_acc2", 0, 2, 32'h0000_3008);
        k_rd = 1; k_npc = 32'h0000_4010;
        tick();
        k_rd = 0;
        tick();
        chk("wait_rd_flush", 32'(if_valid), 32'd0);
        pbase = pop_log.size();
        for (int i = 0; i < 40 && pop_log.size() <= pbase; i++) tick();
        chk_log("wait_rd_next_req", 0, 3, 32'h0000_4010);
        chk_log("wait_rd_first_pop", 1, pbase, 32'h0000_4010);

        // redirect in REQ while memory stalls
        k_lat = 1; k_ready = 0;
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        k_rd = 1; k_npc = 32'h0000_5002;
        tick();
        k_rd = 0;
        tick();
        chk("req_rd_addr", imem_addr, 32'h0000_5000);
        chk("req_rd_req", 32'(imem_req), 32'd1);
        abase = acc_log.size();
        pbase = pop_log.size();
        k_ready = 1;
        for (int i = 0; i < 30 && pop_log.size() <= pbase; i++) tick();
        chk_log("req_rd_acc", 0, abase, 32'h0000_5000);
        chk_log("req_rd_pop", 1, pbase, 32'h0000_5000);

        // address wrap
        k_rd = 1; k_npc = 32'hFFFF_FFFC;
        tick();
        k_rd = 0;
        tick();
        abase = acc_log.size();
        for (int i = 0; i < 30 && acc_log.size() < abase + 2; i++) tick();
        chk_log("wrap_top", 0, abase, 32'hFFFF_FFFC);
        chk_log("wrap_zero", 0, abase + 1, 32'h0000_0000);

        // reset during WAIT, stray response afterwards
        k_lat = 3;
        abase = acc_log.size();
        for (int i = 0; i < 30 && acc_log.size() <= abase; i++) tick();
        tick();
        rst_n = 1'b0;
        k_spur = 1;
        tick(); tick();
        acc_log.delete(); pop_log.delete();
        rst_n = 1'b1;
        chk("rst_mid_valid", 32'(if_valid), 32'd0);
        k_spur = 0; k_lat = 1;
        tick();
        chk("rst_mid_valid_c1", 32'(if_valid), 32'd0);
        for (int i = 0; i < 30 && pop_log.size() < 1; i++) tick();
        chk_log("rst_mid_restart", 0, 0, 32'h0000_3000);
        chk_log("rst_mid_pop", 1, 0, 32'h0000_3000);

        // randomized traffic
        rbase = pop_log.size();
        for (int c = 0; c < 3000; c++) begin
            k_ready = ($urandom_range(0, 9) < 7);
            k_idr   = ($urandom_range(0, 9) < 7);
            k_rd    = ($urandom_range(0, 15) == 0);
            k_npc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                                  : $urandom();
            k_lat   = int'($urandom_range(1, 3));
            k_spur  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                tick(); tick();
                rst_n = 1'b1;
            end
            tick();
        end
        chk("random_throughput", 32'(pop_log.size() - rbase > 200), 32'd1);

        k_rd = 0; k_spur = 0; k_ready = 1; k_idr = 1;
        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
